// File: rtl/uart_rx_param_if.sv
// Output side of the parametrised UART receiver: received word, status flags and
// the valid/ready handshake toward the consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_ready;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 o_busy;

  modport master (
    input  i_ready,
    output o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy
  );

  modport slave (
    output i_ready,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF sync, 3-sample majority vote, optional parity,
// 1/2 stop bits, break handling and a valid/ready output with overrun detection.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_rx,
  uart_rx_param_if.master rx_if
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF      = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PAR      = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_BRK_WAIT = 3'd5;

  logic                 rx_meta_reg, rx_s_reg;
  logic [1:0]           rx_hist_reg;
  logic [1:0]           fill_reg;
  logic                 armed_reg;
  logic                 vote;
  logic [2:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next, store_idx;
  logic                 stop_reg, stop_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 frame_bad;
  logic                 data_store, commit;
  logic [DATA_BITS-1:0] word_reg, data_reg;
  logic                 valid_reg, perr_out_reg, ferr_out_reg, overrun_reg;

  // fill_reg marks when rx_s_reg holds a real line sample rather than its reset value,
  // so a line held low across reset release can never arm the receiver.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_hist_reg <= 2'b11;
      fill_reg    <= 2'b00;
      armed_reg   <= 1'b0;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s_reg    <= rx_meta_reg;
      rx_hist_reg <= {rx_hist_reg[0], rx_s_reg};
      fill_reg    <= {fill_reg[0], 1'b1};
      if (fill_reg[1] && rx_s_reg) armed_reg <= 1'b1;
    end
  end

  assign vote = (rx_s_reg & rx_hist_reg[0]) | (rx_s_reg & rx_hist_reg[1]) |
                (rx_hist_reg[0] & rx_hist_reg[1]);
  assign frame_bad = ferr_reg | ~vote;
  assign store_idx = (MSB_FIRST != 0) ? (IDX_LAST - idx_reg) : idx_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    stop_next  = stop_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    data_store = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next  = '0;
        idx_next  = '0;
        stop_next = 1'b0;
        perr_next = 1'b0;
        ferr_next = 1'b0;
        if (!rx_s_reg && armed_reg) state_next = ST_START;
      end
      ST_START: begin
        if (cnt_reg == HALF) begin
          cnt_next   = '0;
          state_next = vote ? ST_IDLE : ST_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          data_store = 1'b1;
          if (idx_reg == IDX_LAST) state_next = (PARITY != 0) ? ST_PAR : ST_STOP;
          else                     idx_next   = idx_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_PAR: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          perr_next  = ((^word_reg) ^ vote) != (PARITY == 1);
          state_next = ST_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next  = '0;
          ferr_next = frame_bad;
          if (stop_reg == STOP_LAST) begin
            commit     = 1'b1;
            state_next = vote ? ST_IDLE : ST_BRK_WAIT;
          end else begin
            stop_next = stop_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_BRK_WAIT: begin
        if (rx_s_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      stop_reg  <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      stop_reg  <= stop_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                                     word_reg[gi] <= 1'b0;
      else if (data_store && store_idx == IDX_W'(gi))  word_reg[gi] <= vote;
    end
  end

  // A commit while the previous word is still unaccepted drops the new word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (commit && valid_reg && !rx_if.i_ready) begin
        overrun_reg <= 1'b1;
      end else if (commit) begin
        data_reg     <= word_reg;
        perr_out_reg <= perr_reg;
        ferr_out_reg <= frame_bad;
        valid_reg    <= 1'b1;
      end else if (valid_reg && rx_if.i_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_if.o_data       = data_reg;
  assign rx_if.o_valid      = valid_reg;
  assign rx_if.o_parity_err = perr_out_reg;
  assign rx_if.o_frame_err  = ferr_out_reg;
  assign rx_if.o_overrun    = overrun_reg;
  assign rx_if.o_busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four configurations on one clock, a frame-level
// expectation model per receiver and a single compare process on the output handshake.
module tb_uart_rx_param;
  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  localparam int NDUT = 4;
  // 0: 8N1 @868   1: 7E2 @16   2: 8N1 @16   3: 9N1 MSB-first @16
  int cfg_cpb  [NDUT] = '{868, 16, 16, 16};
  int cfg_db   [NDUT] = '{8, 7, 8, 9};
  int cfg_par  [NDUT] = '{0, 2, 0, 0};
  int cfg_stop [NDUT] = '{1, 2, 1, 1};
  int cfg_msb  [NDUT] = '{0, 0, 0, 1};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rst3_ctl;
  logic            rst3_n;
  logic [NDUT-1:0] rx_line;
  logic [NDUT-1:0] ready;

  logic [8:0]      o_data [NDUT];
  logic [NDUT-1:0] o_valid, o_perr, o_ferr, o_ovr, o_busy;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q    [NDUT][$];
  exp_t       cur_exp  [NDUT];
  int         words    [NDUT];
  int         ovr_cnt  [NDUT];
  logic [8:0] last_data[NDUT];
  logic       last_perr[NDUT];
  logic       last_ferr[NDUT];

  always #5 clk = ~clk;
  assign rst3_n = rst_n & rst3_ctl;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(7)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8)) if2 ();
  uart_rx_param_if #(.DATA_BITS(9)) if3 ();

  uart_rx_param #(.CLKS_PER_BIT(868), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0))
    u0 (.i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[0]), .rx_if(if0));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(0))
    u1 (.i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[1]), .rx_if(if1));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0))
    u2 (.i_clk(clk), .i_rst_n(rst3_n), .i_rx(rx_line[2]), .rx_if(if2));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1))
    u3 (.i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[3]), .rx_if(if3));

  assign if0.i_ready = ready[0];
  assign if1.i_ready = ready[1];
  assign if2.i_ready = ready[2];
  assign if3.i_ready = ready[3];

  assign o_data[0] = {1'b0, if0.o_data};
  assign o_data[1] = {2'b0, if1.o_data};
  assign o_data[2] = {1'b0, if2.o_data};
  assign o_data[3] = if3.o_data;
  assign o_valid = {if3.o_valid, if2.o_valid, if1.o_valid, if0.o_valid};
  assign o_perr  = {if3.o_parity_err, if2.o_parity_err, if1.o_parity_err, if0.o_parity_err};
  assign o_ferr  = {if3.o_frame_err, if2.o_frame_err, if1.o_frame_err, if0.o_frame_err};
  assign o_ovr   = {if3.o_overrun, if2.o_overrun, if1.o_overrun, if0.o_overrun};
  assign o_busy  = {if3.o_busy, if2.o_busy, if1.o_busy, if0.o_busy};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Frame model: the expected word, parity flag and frame flag follow from what is put
  // on the wire; bit order only affects the serialisation, never the expected word.
  task automatic send_frame(input int d, input logic [8:0] word, input int pmode,
                            input logic stop_val, input int period100, input bit push);
    logic       bits[$];
    logic [8:0] mask;
    logic       good_par, pbit;
    exp_t       e;
    int         nd, cyc;
    nd       = cfg_db[d];
    mask     = 9'((1 << nd) - 1);
    good_par = ($countones(word & mask) % 2 == 1) ^ (cfg_par[d] == 1);
    pbit     = (pmode < 0) ? good_par : pmode[0];
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(cfg_msb[d] != 0 ? word[nd-1-i] : word[i]);
    if (cfg_par[d] != 0) bits.push_back(pbit);
    for (int s = 0; s < cfg_stop[d]; s++) bits.push_back(stop_val);
    e.data = word & mask;
    e.perr = (cfg_par[d] != 0) && (pbit != good_par);
    e.ferr = !stop_val;
    if (push) exp_q[d].push_back(e);
    for (int k = 0; k < bits.size(); k++) begin
      rx_line[d] = bits[k];
      cyc = ((k + 1) * period100) / 100 - (k * period100) / 100;
      repeat (cyc) @(negedge clk);
    end
    rx_line[d] = 1'b1;
  endtask

  // Compare process: every newly presented word against the model, every held cycle for stability.
  initial begin
    logic [NDUT-1:0] prev_valid, prev_ready;
    prev_valid = '0;
    prev_ready = '0;
    for (int d = 0; d < NDUT; d++) begin
      words[d] = 0; ovr_cnt[d] = 0; last_data[d] = '0; last_perr[d] = 1'b0; last_ferr[d] = 1'b0;
      cur_exp[d] = '0;
    end
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int d = 0; d < NDUT; d++) begin
          if (o_ovr[d] === 1'b1) ovr_cnt[d]++;
          if (o_valid[d] === 1'b1) begin
            if (!prev_valid[d] || prev_ready[d]) begin
              words[d]++;
              last_data[d] = o_data[d];
              last_perr[d] = o_perr[d];
              last_ferr[d] = o_ferr[d];
              if (exp_q[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word dut%0d: got 0x%0h, expected no word", d, o_data[d]);
              end else begin
                cur_exp[d] = exp_q[d].pop_front();
                check($sformatf("word_data dut%0d", d), 32'(o_data[d]), 32'(cur_exp[d].data));
                check($sformatf("word_perr dut%0d", d), 32'(o_perr[d]), 32'(cur_exp[d].perr));
                check($sformatf("word_ferr dut%0d", d), 32'(o_ferr[d]), 32'(cur_exp[d].ferr));
              end
            end else begin
              check($sformatf("held_data dut%0d", d), 32'(o_data[d]), 32'(cur_exp[d].data));
            end
          end
          prev_valid[d] = o_valid[d];
          prev_ready[d] = ready[d];
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat, w0;
    bit  busy_any;
    logic v_after;
    rst_n    = 1'b0;
    rst3_ctl = 1'b1;
    rx_line  = '1;
    ready    = '1;
    repeat (5) @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("reset_outputs dut%0d", d),
            32'({o_data[d], o_valid[d], o_perr[d], o_ferr[d], o_ovr[d], o_busy[d]}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("after_reset_busy", 32'(o_busy), 32'd0);

    // T1: 8N1 at 868 clocks per bit, latency 4+433+868*9 = 8249
    lat = 0;
    v_after = 1'b1;
    fork
      send_frame(0, 9'h0A5, -1, 1'b1, 86800, 1'b1);
      begin
        while (o_valid[0] !== 1'b1 && lat < 8400) begin
          @(posedge clk);
          lat++;
          #1;
        end
        @(posedge clk);
        #1 v_after = o_valid[0];
      end
    join
    check_range("t1_latency", lat, 8247, 8251);
    check("t1_valid_one_cycle", 32'(v_after), 32'd0);
    check("t1_data", 32'(last_data[0]), 32'h0A5);
    check("t1_flags", 32'({last_perr[0], last_ferr[0]}), 32'd0);
    check("t1_words", 32'(words[0]), 32'd1);

    // T2: 7E2, 0x55 has four ones so the correct even parity bit is 0
    send_frame(1, 9'h055, 1, 1'b1, 1600, 1'b1);
    repeat (4) @(negedge clk);
    check("t2_bad_parity_data", 32'(last_data[1]), 32'h055);
    check("t2_bad_parity_flag", 32'(last_perr[1]), 32'd1);
    send_frame(1, 9'h055, 0, 1'b1, 1600, 1'b1);
    repeat (4) @(negedge clk);
    check("t2_good_parity_flag", 32'(last_perr[1]), 32'd0);
    check("t2_words", 32'(words[1]), 32'd2);

    // T3: glitch rejection
    w0 = words[2];
    rx_line[2] = 1'b0;
    repeat (3) @(negedge clk);
    rx_line[2] = 1'b1;
    check("t3_glitch_busy_seen", 32'(o_busy[2]), 32'd1);
    repeat (9) @(negedge clk);
    check("t3_glitch_busy_cleared", 32'(o_busy[2]), 32'd0);
    repeat (40) @(negedge clk);
    check("t3_glitch_no_word", 32'(words[2] - w0), 32'd0);

    // T3: low stop bit
    send_frame(2, 9'h03C, -1, 1'b0, 1600, 1'b1);
    repeat (10) @(negedge clk);
    check("t3_frame_data", 32'(last_data[2]), 32'h03C);
    check("t3_frame_flag", 32'(last_ferr[2]), 32'd1);
    check("t3_frame_idle", 32'(o_busy[2]), 32'd0);

    // T3: break held for three frame times
    w0 = words[2];
    exp_q[2].push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1});
    rx_line[2] = 1'b0;
    repeat (480) @(negedge clk);
    rx_line[2] = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_break_words", 32'(words[2] - w0), 32'd1);
    check("t3_break_data", 32'(last_data[2]), 32'h000);
    check("t3_break_flag", 32'(last_ferr[2]), 32'd1);
    check("t3_break_idle", 32'(o_busy[2]), 32'd0);

    // T4: overrun with consumer stalled
    ready[2] = 1'b0;
    send_frame(2, 9'h011, -1, 1'b1, 1600, 1'b1);
    send_frame(2, 9'h022, -1, 1'b1, 1600, 1'b0);
    repeat (5) @(negedge clk);
    check("t4_held_data", 32'(o_data[2]), 32'h011);
    check("t4_held_valid", 32'(o_valid[2]), 32'd1);
    check("t4_overrun_once", 32'(ovr_cnt[2]), 32'd1);

    // T4: ready rises on the commit cycle of 0x33 (valid appears after edge 4+7+144 = 155)
    fork
      send_frame(2, 9'h033, -1, 1'b1, 1600, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 ready[2] = 1'b1;
        @(posedge clk);
        #1;
        check("t4_same_cycle_data", 32'(o_data[2]), 32'h033);
        check("t4_same_cycle_valid", 32'(o_valid[2]), 32'd1);
        check("t4_same_cycle_no_overrun", 32'(o_ovr[2]), 32'd0);
      end
    join
    repeat (5) @(negedge clk);
    check("t4_overrun_total", 32'(ovr_cnt[2]), 32'd1);
    check("t4_valid_drained", 32'(o_valid[2]), 32'd0);

    // T5: reset in the middle of the first data bit, released with the line low
    rx_line[2] = 1'b0;
    repeat (24) @(negedge clk);
    check("t5_busy_before_reset", 32'(o_busy[2]), 32'd1);
    rst3_ctl = 1'b0;
    #1;
    check("t5_async_reset_outputs",
          32'({o_data[2], o_valid[2], o_perr[2], o_ferr[2], o_ovr[2], o_busy[2]}), 32'd0);
    repeat (3) @(negedge clk);
    rst3_ctl = 1'b1;
    busy_any = 1'b0;
    repeat (60) begin
      @(negedge clk);
      busy_any |= (o_busy[2] | o_valid[2]);
    end
    check("t5_no_start_while_low", 32'(busy_any), 32'd0);
    rx_line[2] = 1'b1;
    repeat (20) @(negedge clk);
    w0 = words[2];
    send_frame(2, 9'h05A, -1, 1'b1, 1600, 1'b1);
    repeat (5) @(negedge clk);
    check("t5_after_reset_data", 32'(last_data[2]), 32'h05A);
    check("t5_after_reset_words", 32'(words[2] - w0), 32'd1);

    // T6: 9 bits MSB first with +3% and -3% baud error
    send_frame(3, 9'h1C3, -1, 1'b1, 1648, 1'b1);
    repeat (5) @(negedge clk);
    check("t6_slow_data", 32'(last_data[3]), 32'h1C3);
    check("t6_slow_flags", 32'({last_perr[3], last_ferr[3]}), 32'd0);
    send_frame(3, 9'h1C3, -1, 1'b1, 1552, 1'b1);
    repeat (5) @(negedge clk);
    check("t6_fast_data", 32'(last_data[3]), 32'h1C3);
    check("t6_words", 32'(words[3]), 32'd2);

    repeat (10) @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("leftover_expected dut%0d", d), 32'(exp_q[d].size()), 32'd0);
    check("overrun_dut0", 32'(ovr_cnt[0]), 32'd0);
    check("overrun_dut1", 32'(ovr_cnt[1]), 32'd0);
    check("overrun_dut3", 32'(ovr_cnt[3]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
